// File: rtl/ad_capture_pkg.sv
// Shared types for the ADC capture controller: FSM state encoding and trigger slope codes.
// Optional auto-trigger timeout is enabled by defining AD_CAPTURE_TIMEOUT_EN.
package ad_capture_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/ad_trig_detect.sv
// Level-crossing trigger detector: remembers the last strobed sample and flags a
// rising or falling crossing of the threshold on the current strobe.
module ad_trig_detect
  import ad_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic                  slope,
  output logic                  trig_c
);

  logic [DATA_WIDTH-1:0] prev;
  logic                  rise_c;
  logic                  fall_c;

  // prev follows every strobe regardless of capture state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else if (strobe) begin
      prev <= sample;
    end
  end

  assign rise_c = (prev <  level) && (sample >= level);
  assign fall_c = (prev >= level) && (sample <  level);
  assign trig_c = strobe && ((slope == SLOPE_FALL) ? fall_c : rise_c);

endmodule

// File: rtl/ad_capture.sv
// Decimating ADC capture writer: fills a circular sample RAM with a pre/post-trigger frame.
// Define AD_CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_CYCLES clocks in WAIT.
module ad_capture
  import ad_capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRE_DEPTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ad_data,
  input  logic [7:0]            decim,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_slope,
  input  logic                  arm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  timed_out
);

  localparam int unsigned N        = 2 ** ADDR_WIDTH;
  localparam int unsigned POST_CNT = N - PRE_DEPTH - 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS   = ADDR_WIDTH'(PRE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = ADDR_WIDTH'(PRE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] POST_INIT = ADDR_WIDTH'(POST_CNT);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [7:0]            dcnt;
  logic [7:0]            dlim;
  logic                  strobe_c;
  logic                  cap_c;
  logic                  arm_ok_c;
  logic                  trig_c;
  logic                  trig_eff_c;

  // Decimator: the period is latched at each wrap so a decim change applies next period
  assign strobe_c = (dcnt == dlim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 8'd0;
      dlim <= 8'd0;
    end else if (strobe_c) begin
      dcnt <= 8'd0;
      dlim <= decim;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end

  assign cap_c    = (state == PRE) || (state == WAIT) || (state == POST);
  assign arm_ok_c = arm && ((state == IDLE) || (state == DONE));

  ad_trig_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_trig (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe_c),
    .sample (ad_data),
    .level  (trig_level),
    .slope  (trig_slope),
    .trig_c (trig_c)
  );

`ifdef AD_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit_c;

  assign to_hit_c = (to_cnt >= TO_W'(TIMEOUT_CYCLES));

  // Saturating WAIT-time counter, held at zero outside WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != WAIT) begin
      to_cnt <= '0;
    end else if (!to_hit_c) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign trig_eff_c = trig_c || (strobe_c && to_hit_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out <= 1'b0;
    end else if (arm_ok_c) begin
      timed_out <= 1'b0;
    end else if ((state == WAIT) && strobe_c && to_hit_c && !trig_c) begin
      timed_out <= 1'b1;
    end
  end
`else
  assign trig_eff_c = trig_c;
  // No auto-trigger in this build; the timeout parameter has no effect
  assign timed_out  = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Capture FSM with registered RAM write port and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      trig_addr  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      if (strobe_c && cap_c) begin
        wr_en   <= 1'b1;
        wr_addr <= ptr;
        wr_data <= ad_data;
        ptr     <= ptr + ADDR_ONE;
      end

      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state <= (PRE_DEPTH == 0) ? WAIT : PRE;
            ptr   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        PRE: begin
          if (strobe_c) begin
            if (cnt == PRE_LAST) begin
              state <= WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_ONE;
            end
          end
        end
        WAIT: begin
          if (trig_eff_c) begin
            trig_addr <= ptr;
            if (POST_CNT == 0) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              start_addr <= ptr - PRE_OFS;
            end else begin
              state <= POST;
              cnt   <= POST_INIT;
            end
          end
        end
        POST: begin
          if (strobe_c) begin
            if (cnt == ADDR_ONE) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              start_addr <= trig_addr - PRE_OFS;
            end else begin
              cnt <= cnt - ADDR_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad_capture.sv
// Randomised scoreboard bench for ad_capture: a frame-level reference model predicts
// every RAM write and the status outputs; a negedge monitor checks the DUT against it.
module tb_ad_capture;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 8;
  localparam int          PRE = 4;
  localparam int          TO  = 64;
  localparam int          N   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ad_data = '0;
  logic [7:0]    decim = 8'd0;
  logic [DW-1:0] trig_level = 8'd20;
  logic          trig_slope = 1'b0;
  logic          arm = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] start_addr;
  logic          timed_out;

  ad_capture #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .PRE_DEPTH      (PRE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ad_data    (ad_data),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .arm        (arm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .start_addr (start_addr),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   dut_ram[N];
  int   mode = 0;

  // frame-level reference state
  int   m_dcnt = 0, m_dlim = 0, m_prev = 0, m_wk = 0, m_start = 0;
  int   nwr = 0, trig_idx = -1;
  bit   m_busy = 0, m_done = 0, m_tout = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts writes of the frame; frame ends N-PRE writes after the trigger write
  always @(posedge clk or posedge rst) begin : model
    bit strobe, waiting, to_hit, cond, trig;
    if (rst) begin
      m_dcnt = 0; m_dlim = 0; m_prev = 0; m_wk = 0; m_start = 0;
      nwr = 0; trig_idx = -1; m_busy = 0; m_done = 0; m_tout = 0;
      exp_q.delete();
    end else begin
      strobe = (m_dcnt == m_dlim);
      if (strobe) begin
        m_dcnt = 0;
        m_dlim = int'(decim);
      end else begin
        m_dcnt = m_dcnt + 1;
      end
      waiting = m_busy && (nwr >= PRE) && (trig_idx < 0);
      to_hit  = 1'b0;
`ifdef AD_CAPTURE_TIMEOUT_EN
      to_hit  = waiting && (m_wk >= TO);
`endif
      m_wk = waiting ? m_wk + 1 : 0;
      if (m_busy && strobe) begin
        if (trig_slope == 1'b0)
          cond = (m_prev < int'(trig_level)) && (int'(ad_data) >= int'(trig_level));
        else
          cond = (m_prev >= int'(trig_level)) && (int'(ad_data) < int'(trig_level));
        trig = waiting && (cond || to_hit);
        if (trig && !cond) m_tout = 1'b1;
        if (trig) trig_idx = nwr;
        exp_q.push_back('{addr: nwr % N, data: int'(ad_data)});
        nwr = nwr + 1;
        if ((trig_idx >= 0) && (nwr == trig_idx + N - PRE)) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_start = ((trig_idx - PRE) % N + N) % N;
        end
      end else if (!m_busy && arm) begin
        m_busy = 1'b1; m_done = 1'b0; m_tout = 1'b0;
        nwr = 0; trig_idx = -1;
      end
      if (strobe) m_prev = int'(ad_data);
    end
  end

  // Monitor: pops one expected write per observed write, checks status every cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wr_en || (exp_q.size() != 0))
      chk("wr_en", int'(wr_en), int'(exp_q.size() != 0));
    if (wr_en && (exp_q.size() != 0)) begin
      e = exp_q.pop_front();
      chk("wr_addr", int'(wr_addr), e.addr);
      chk("wr_data", int'(wr_data), e.data);
    end
    if (wr_en) dut_ram[wr_addr] = int'(wr_data);
    exp_q.delete();
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    if (m_done) chk("start_addr", int'(start_addr), m_start);
    chk("timed_out", int'(timed_out), int'(m_tout));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    arm = 1'b0;
    case (mode)
      0:       ad_data = ad_data + 8'd1;
      1:       ad_data = ad_data - 8'd1;
      2:       ad_data = 8'd5;
      default: ad_data = DW'($urandom_range(255));
    endcase
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"},      int'(wr_en),      0);
    chk({tag, "_wr_addr"},    int'(wr_addr),    0);
    chk({tag, "_wr_data"},    int'(wr_data),    0);
    chk({tag, "_busy"},       int'(busy),       0);
    chk({tag, "_done"},       int'(done),       0);
    chk({tag, "_start_addr"}, int'(start_addr), 0);
    chk({tag, "_timed_out"},  int'(timed_out),  0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk_zero("reset");
    rst = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit noise, input bit post_arm);
    int k = 0;
    bit armed = 1'b0;
    while (!done && (k < limit)) begin
      if (noise && m_busy && ($urandom_range(7) == 0)) arm = 1'b1;
      if (post_arm && !armed && m_busy && (trig_idx >= 0)) begin
        arm   = 1'b1;
        armed = 1'b1;
      end
      cyc();
      k++;
    end
    chk("done_wait", int'(done), 1);
    if (!done) do_reset();
  endtask

  // One capture: configure, arm, confirm arm response, run to done, optionally check trigger sample
  task automatic frame(input int md, input int dc, input int lvl, input bit slp,
                       input int start_val, input int exp_trig, input bit noise, input bit post_arm);
    mode       = md;
    decim      = 8'(dc);
    trig_level = DW'(lvl);
    trig_slope = slp;
    ad_data    = DW'(start_val);
    arm        = 1'b1;
    cyc();
    chk("arm_busy", int'(busy), 1);
    chk("arm_done", int'(done), 0);
    wait_done(3000, noise, post_arm);
    if ((exp_trig >= 0) && done) begin
      @(negedge clk);
      #1;
      chk("trig_sample", dut_ram[(int'(start_addr) + PRE) % N], exp_trig);
    end
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk_zero("por");
    rst = 1'b0;
    cyc();

    frame(0, 0, 20, 1'b0, 0, 20, 1'b0, 1'b0);
    frame(1, 0, 100, 1'b1, 255, 99, 1'b0, 1'b0);
    frame(0, 3, 20, 1'b0, 0, -1, 1'b0, 1'b0);
    frame(0, 0, 20, 1'b0, 0, 20, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      frame(3, int'($urandom_range(3)), int'($urandom_range(16, 240)), 1'($urandom_range(1)),
            0, -1, 1'b1, 1'b0);

`ifdef AD_CAPTURE_TIMEOUT_EN
    frame(2, 0, 20, 1'b0, 5, -1, 1'b0, 1'b0);
    chk("timeout_flag", int'(timed_out), 1);
`else
    mode       = 2;
    decim      = 8'd0;
    trig_level = 8'd20;
    trig_slope = 1'b0;
    arm        = 1'b1;
    cyc();
    repeat (10000) cyc();
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_done", int'(done), 0);
    do_reset();
`endif

    // reset while in the post-trigger phase
    mode       = 0;
    decim      = 8'd0;
    trig_level = 8'd20;
    trig_slope = 1'b0;
    ad_data    = 8'd0;
    arm        = 1'b1;
    cyc();
    for (int k = 0; (k < 200) && !(m_busy && (trig_idx >= 0)); k++) cyc();
    cyc();
    chk("post_reached_busy", int'(busy), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid_post");
    cyc();
    cyc();
    rst = 1'b0;
    repeat (20) cyc();
    chk("idle_after_rst", int'(busy), 0);

    frame(0, 1, 20, 1'b0, 0, -1, 1'b0, 1'b0);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 5ms", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ad_capture.md
# ad_capture

ADC-side capture controller for the AN108 AD/DA + HDMI design: the writer feeding the sample RAM that the display path reads back. Decimates the 8-bit ADC stream and fills a circular dual-port RAM through a pre-trigger / trigger / post-trigger state machine. Reports where the captured frame starts and flags completion for the display reader.

## Interface
- ADDR_WIDTH, 10, RAM address width; buffer depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 8, ADC sample width
- PRE_DEPTH, 256, samples kept before trigger; legal range 0..N-1
- TIMEOUT_CYCLES, 1048576, auto-trigger timeout in clk cycles (used only with macro)

- clk  in  1  capture clock, same clock as ADC data
- rst  in  1  asynchronous, active-high reset
- ad_data  in  DATA_WIDTH  ADC sample, valid every clk
- decim  in  8  capture one sample every decim+1 clocks
- trig_level  in  DATA_WIDTH  unsigned trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- arm  in  1  one-cycle start/rearm request
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_WIDTH  RAM write address
- wr_data  out  DATA_WIDTH  RAM write data
- busy  out  1  high in PRE, WAIT, POST
- done  out  1  frame complete, held until next accepted arm
- start_addr  out  ADDR_WIDTH  address of oldest sample in frame, valid while done
- timed_out  out  1  frame was auto-triggered (constant 0 without macro)

## Operation
- Decimator: free-running counter 0..decim; strobe when counter == decim, then counter returns to 0. decim = 0 gives strobe every cycle. decim change takes effect at next wrap.
- prev: last strobed sample, updated on every strobe in every state.
- Trigger (on strobe): rising = prev < trig_level && ad_data >= trig_level; falling = prev >= trig_level && ad_data < trig_level. Unsigned compare.
- Write: on a strobe in PRE/WAIT/POST, next cycle wr_en=1, wr_data=ad_data, wr_addr=ptr; ptr increments mod N.
- States:
  - IDLE: arm -> PRE (PRE_DEPTH=0 -> WAIT); ptr<=0, cnt<=0, done<=0.
  - PRE: write each strobe, cnt++; after PRE_DEPTH writes -> WAIT. Triggers ignored.
  - WAIT: write each strobe, ptr wraps freely; strobe with trigger: sample written, trig_addr<=ptr, cnt<=N-PRE_DEPTH-1 -> POST (cnt=0 -> DONE).
  - POST: write each strobe, cnt--; on last write -> DONE.
  - DONE: done=1, start_addr=(trig_addr-PRE_DEPTH) mod N; arm -> PRE (same as IDLE).
- arm while busy ignored. Frame = PRE_DEPTH pre samples, trigger sample at start_addr+PRE_DEPTH, N-PRE_DEPTH-1 post samples; exactly N writes total after PRE completes the buffer wrap.
- Reset mid-capture: all state lost, IDLE, no writes; RAM contents undefined to reader.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, start_addr 0, timed_out 0; state IDLE; decim counter 0; prev 0.
- arm to busy: 1 cycle. Strobe to wr_en: 1 cycle (registered outputs).
- done and start_addr rise same cycle as the final wr_en; busy falls that cycle.
- Trigger on the first WAIT strobe is legal; prev then holds last PRE sample.

## Configuration
- AD_CAPTURE_TIMEOUT_EN defined: in WAIT a cycle counter runs from 0; at TIMEOUT_CYCLES the next strobe is treated as trigger regardless of level, timed_out<=1 (cleared on accepted arm). Counter cleared on WAIT entry.
- Undefined: no timeout logic; WAIT persists until a real trigger; timed_out tied 0.

## Structure
- ad_capture_pkg: state typedef (IDLE, PRE, WAIT, POST, DONE), slope constants SLOPE_RISE/SLOPE_FALL.
- Sub-module ad_trig_detect: prev register plus slope/level compare, outputs trig on strobe.

## Test plan
- ADDR_WIDTH=4, PRE_DEPTH=4, decim=0, ramp 0..255, trig_level=20, rising, arm -> 16 writes after PRE, trigger sample 20 at start_addr+4, done with start_addr = trig_addr-4 mod 16.
- Same with trig_slope=1, ramp 255..0, trig_level=100 -> trigger sample 99, first write whose value < 100.
- decim=3 -> wr_en exactly every 4th cycle, data = every 4th ramp value.
- Constant ad_data=5, level 20, with AD_CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=64 -> done, timed_out=1; without macro -> busy stays 1 for 10000 cycles.
- arm pulse during POST -> ignored, frame completes normally; arm in DONE -> done falls next cycle, new capture.
- rst asserted mid-POST -> all outputs 0 immediately, no wr_en until new arm.
